modport_chip: RTL and testbench
===============================

MODPORT_CHIP -- requirements
Module: modport_chip

Interface
REQ-001 SHALL take one parameter cfg of type config_t with fields: DATA_WIDTH (16, operand/result bits); FEATURE_MAP_WIDTH (128); FEATURE_MAP_HEIGHT (128); INPUT_NB_CHANNELS (2); OUTPUT_NB_CHANNELS (32); KERNEL_SIZE (3, odd); FRACTIONAL_BITS (8, result right-shift).
REQ-002 Ports, one clock; reset is asynchronous and active-high:
- clk  in  1  clock
- arst_n  in  1  asynchronous reset, asserted at 1
- int_mem_we  in  1  load mode: a/b handshakes write weight memory
- data_ready  in  1  one-cycle pulse: weight load complete
- fsm_done  out  1  one-cycle pulse: last output produced
- a_input  in  DATA_WIDTH  load: weight address; compute: activation (signed)
- a_valid  in  1;  a_ready  out  1
- b_input  in  DATA_WIDTH  load: weight data (signed)
- b_valid  in  1;  b_ready  out  1
- output_data  out  DATA_WIDTH  signed result
- output_valid  out  1  result strobe, no backpressure
- output_x  out  clog2(FEATURE_MAP_WIDTH);  output_y  out  clog2(FEATURE_MAP_HEIGHT);  output_ch  out  clog2(OUTPUT_NB_CHANNELS)
- start  in  1  begin convolution;  running  out  1  busy

Function
REQ-003 States IDLE, LOAD, WAIT, COMPUTE; reset -> IDLE.
REQ-004 IDLE/LOAD: int_mem_we=1 -> a_ready=b_ready=1; cycle with a_valid&b_valid&both ready writes b_input to weight memory[a_input]; state LOAD.
REQ-005 data_ready=1 in LOAD -> WAIT; data_ready in other states ignored.
REQ-006 start=1 in WAIT -> COMPUTE next cycle, running=1; start in IDLE/LOAD/COMPUTE ignored.
REQ-007 Weight memory: K*K*Cin*Cout words, address ((ch_out*K+k_v)*K+k_h)*Cin+ch_in; writes beyond range ignored.
REQ-008 COMPUTE loop order outer->inner: y, x, ch_out, k_v, k_h, ch_in; one MAC per a handshake; b_ready=0.
REQ-009 a_ready=1 throughout COMPUTE; each a handshake multiplies signed a_input by the indexed weight and accumulates; bench supplies zero for out-of-bounds positions.
REQ-010 Accumulator width 2*DATA_WIDTH+clog2(K*K*Cin); cleared at first MAC of each output.
REQ-011 Result = accumulator arithmetic-shifted right by FRACTIONAL_BITS, reduced to DATA_WIDTH per REQ-017.
REQ-012 output_valid pulses one cycle after the final MAC (ch_in, k_h, k_v all max) of each output, with output_x/y/ch of that output.
REQ-013 After last output (x,y,ch all max) fsm_done pulses same cycle as that output_valid; running=0 next cycle; state -> WAIT (weights retained, new start reruns).
REQ-014 a_valid low stalls counters; no state change without handshake.

Reset
REQ-015 arst_n=1 asynchronously: state IDLE, counters/accumulator 0, all outputs 0 (a_ready, b_ready, running, output_valid, fsm_done = 0); weight memory contents undefined.
REQ-016 Reset mid-COMPUTE aborts; no output_valid/fsm_done until a fresh load-start sequence.

Configuration
REQ-017 Macro SATURATE_EN: defined -> shifted result clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; undefined -> low DATA_WIDTH bits kept (two's-complement wrap).

Structure
REQ-018 Shared package holds config_t typedef, default cfg constant, state enum.
REQ-019 One sub-module mac_unit (multiply, accumulate, clear, shift/saturate).

Verification
REQ-020 Load all weights = 256 (1.0), all activations 256 -> every output_data = K*K*Cin*256 = 4608 (3x3x2).
REQ-021 SATURATE_EN: weights 32767, activations 32767 -> output_data 32767; without macro -> wrapped low 16 bits.
REQ-022 a_valid toggled 50% randomly -> identical results and order vs continuous stream; output_valid exactly once per (x,y,ch).
REQ-023 start before data_ready -> ignored, running stays 0; after data_ready, start -> running=1 next cycle.
REQ-024 Reset asserted mid-COMPUTE -> all outputs 0 immediately, no fsm_done afterwards.
REQ-025 Full run -> fsm_done coincides with output (x=127,y=127,ch=31), running=0 next cycle.

Source files
------------

// File: rtl/modport_chip_pkg.sv
// modport_chip_pkg: configuration type, default configuration, FSM states and a width helper.
package modport_chip_pkg;

    typedef struct packed {
        int DATA_WIDTH;
        int FEATURE_MAP_WIDTH;
        int FEATURE_MAP_HEIGHT;
        int INPUT_NB_CHANNELS;
        int OUTPUT_NB_CHANNELS;
        int KERNEL_SIZE;
        int FRACTIONAL_BITS;
    } config_t;

    localparam config_t DEFAULT_CFG = '{
        DATA_WIDTH:         16,
        FEATURE_MAP_WIDTH:  128,
        FEATURE_MAP_HEIGHT: 128,
        INPUT_NB_CHANNELS:  2,
        OUTPUT_NB_CHANNELS: 32,
        KERNEL_SIZE:        3,
        FRACTIONAL_BITS:    8
    };

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_COMPUTE} state_t;

    // Counter/port width that stays at least one bit for single-entry ranges.
    function automatic int clog1(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/modport_chip_mac.sv
// mac_unit: signed multiply-accumulate with fixed-point rescale.
// Build option SATURATE_EN: clamp the rescaled result instead of keeping its low DW bits.
module mac_unit #(
    parameter int DW   = 16,
    parameter int ACCW = 37,
    parameter int FB   = 8
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          i_en,
    input  logic          i_clear,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_w,
    output logic [DW-1:0] o_result
);
    logic signed [2*DW-1:0] w_prod;
    logic signed [ACCW-1:0] r_acc;

    assign w_prod = $signed(i_a) * $signed(i_w);

    // One product per enabled cycle; a clear starts a fresh sum with the current product.
    always_ff @(posedge clk or posedge arst_n) begin
        if (arst_n)
            r_acc <= '0;
        else if (i_en)
            r_acc <= (i_clear ? '0 : r_acc) + ACCW'(w_prod);
    end

`ifdef SATURATE_EN
    localparam logic signed [ACCW-1:0] MAXV = ACCW'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] MINV = ~MAXV;
    logic signed [ACCW-1:0] w_sh;
    assign w_sh     = r_acc >>> FB;
    assign o_result = w_sh > MAXV ? DW'(MAXV) : w_sh < MINV ? DW'(MINV) : DW'(w_sh);
`else
    assign o_result = DW'(r_acc >>> FB);
`endif

endmodule

// File: rtl/modport_chip.sv
// modport_chip: KxK multi-channel convolution engine; weights load over a/b, activations stream over a.
// Build option SATURATE_EN: clamp results to DATA_WIDTH instead of wrapping (inside mac_unit).
module modport_chip
    import modport_chip_pkg::*;
#(
    parameter config_t cfg = DEFAULT_CFG
) (
    input  logic                                        clk,
    input  logic                                        arst_n,
    input  logic                                        int_mem_we,
    input  logic                                        data_ready,
    output logic                                        fsm_done,
    input  logic [cfg.DATA_WIDTH-1:0]                   a_input,
    input  logic                                        a_valid,
    output logic                                        a_ready,
    input  logic [cfg.DATA_WIDTH-1:0]                   b_input,
    input  logic                                        b_valid,
    output logic                                        b_ready,
    output logic [cfg.DATA_WIDTH-1:0]                   output_data,
    output logic                                        output_valid,
    output logic [clog1(cfg.FEATURE_MAP_WIDTH)-1:0]     output_x,
    output logic [clog1(cfg.FEATURE_MAP_HEIGHT)-1:0]    output_y,
    output logic [clog1(cfg.OUTPUT_NB_CHANNELS)-1:0]    output_ch,
    input  logic                                        start,
    output logic                                        running
);
    localparam int DW    = cfg.DATA_WIDTH;
    localparam int K     = cfg.KERNEL_SIZE;
    localparam int CIN   = cfg.INPUT_NB_CHANNELS;
    localparam int COUT  = cfg.OUTPUT_NB_CHANNELS;
    localparam int FW    = cfg.FEATURE_MAP_WIDTH;
    localparam int FH    = cfg.FEATURE_MAP_HEIGHT;
    localparam int DEPTH = K * K * CIN * COUT;
    localparam int AW    = clog1(DEPTH);
    localparam int ACCW  = 2 * DW + clog1(K * K * CIN);
    localparam int CIW   = clog1(CIN);
    localparam int KW    = clog1(K);
    localparam int COW   = clog1(COUT);
    localparam int XW    = clog1(FW);
    localparam int YW    = clog1(FH);

    state_t r_state, w_next;
    logic [CIW-1:0] r_ci;
    logic [KW-1:0]  r_kh, r_kv;
    logic [COW-1:0] r_co, r_och;
    logic [XW-1:0]  r_x, r_ox;
    logic [YW-1:0]  r_y, r_oy;
    logic           r_ov, r_done, r_running;
    logic [DW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  w_raddr;
    logic           w_load_ok, w_load_hs, w_mac, w_go, w_first, w_last_mac, w_last_out;
    logic           w_ci_max, w_kh_max, w_kv_max, w_co_max, w_x_max, w_y_max;

    assign w_load_hs  = a_valid && b_valid && a_ready && b_ready;
    assign w_mac      = r_state == S_COMPUTE && a_valid && a_ready;
    assign w_go       = r_state == S_WAIT && start;
    assign w_ci_max   = r_ci == CIW'(CIN - 1);
    assign w_kh_max   = r_kh == KW'(K - 1);
    assign w_kv_max   = r_kv == KW'(K - 1);
    assign w_co_max   = r_co == COW'(COUT - 1);
    assign w_x_max    = r_x == XW'(FW - 1);
    assign w_y_max    = r_y == YW'(FH - 1);
    assign w_first    = r_ci == '0 && r_kh == '0 && r_kv == '0;
    assign w_last_mac = w_mac && w_ci_max && w_kh_max && w_kv_max;
    assign w_last_out = w_last_mac && w_co_max && w_x_max && w_y_max;
    assign w_raddr    = AW'(((int'(r_co) * K + int'(r_kv)) * K + int'(r_kh)) * CIN + int'(r_ci));

    // State register.
    always_ff @(posedge clk or posedge arst_n) begin
        if (arst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next state: load until data_ready, wait for start, compute until the last output.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_load_hs) w_next = S_LOAD;
            S_LOAD:    if (data_ready) w_next = S_WAIT;
            S_WAIT:    if (start) w_next = S_COMPUTE;
            S_COMPUTE: if (w_last_out) w_next = S_WAIT;
            default:   w_next = S_IDLE;
        endcase
    end

    // Handshake readiness; forced low while reset is asserted.
    always_comb begin
        w_load_ok = int_mem_we && (r_state == S_IDLE || r_state == S_LOAD);
        a_ready   = !arst_n && (w_load_ok || r_state == S_COMPUTE);
        b_ready   = !arst_n && w_load_ok;
    end

    // Weight memory: contents are not reset; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (w_load_hs && 32'(a_input) < DEPTH)
            r_mem[AW'(a_input)] <= b_input;
    end

    // Loop nest y > x > ch_out > k_v > k_h > ch_in, advancing one step per accepted activation.
    always_ff @(posedge clk or posedge arst_n) begin
        if (arst_n) begin
            r_ci <= '0;
            r_kh <= '0;
            r_kv <= '0;
            r_co <= '0;
            r_x  <= '0;
            r_y  <= '0;
        end else if (w_mac) begin
            r_ci <= w_ci_max ? '0 : r_ci + 1'b1;
            if (w_ci_max) begin
                r_kh <= w_kh_max ? '0 : r_kh + 1'b1;
                if (w_kh_max) begin
                    r_kv <= w_kv_max ? '0 : r_kv + 1'b1;
                    if (w_kv_max) begin
                        r_co <= w_co_max ? '0 : r_co + 1'b1;
                        if (w_co_max) begin
                            r_x <= w_x_max ? '0 : r_x + 1'b1;
                            if (w_x_max)
                                r_y <= w_y_max ? '0 : r_y + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Result strobe, coordinates and completion; running stays up through the fsm_done cycle.
    always_ff @(posedge clk or posedge arst_n) begin
        if (arst_n) begin
            r_ov      <= 1'b0;
            r_done    <= 1'b0;
            r_running <= 1'b0;
            r_ox      <= '0;
            r_oy      <= '0;
            r_och     <= '0;
        end else begin
            r_ov      <= w_last_mac;
            r_done    <= w_last_out;
            r_running <= w_go || (r_running && !r_done);
            if (w_last_mac) begin
                r_ox  <= r_x;
                r_oy  <= r_y;
                r_och <= r_co;
            end
        end
    end

    mac_unit #(
        .DW  (DW),
        .ACCW(ACCW),
        .FB  (cfg.FRACTIONAL_BITS)
    ) u_mac (
        .clk     (clk),
        .arst_n  (arst_n),
        .i_en    (w_mac),
        .i_clear (w_first),
        .i_a     (a_input),
        .i_w     (r_mem[w_raddr]),
        .o_result(output_data)
    );

    assign output_valid = r_ov;
    assign fsm_done     = r_done;
    assign running      = r_running;
    assign output_x     = r_ox;
    assign output_y     = r_oy;
    assign output_ch    = r_och;

endmodule

// File: tb/tb_modport_chip.sv
// tb_modport_chip: directed checks of load, gating, convolution results, stalls and reset abort.
module tb_modport_chip;
    import modport_chip_pkg::*;

    localparam int FW = 4, FH = 3, CIN = 2, COUT = 2, K = 3;
    localparam int DEPTH = K * K * CIN * COUT;
    localparam int NMAC = FW * FH * COUT * K * K * CIN;
    localparam int NOUT = FW * FH * COUT;
    localparam int XW = $clog2(FW), YW = $clog2(FH), CW = $clog2(COUT);
    localparam config_t TB_CFG = '{
        DATA_WIDTH: 16, FEATURE_MAP_WIDTH: FW, FEATURE_MAP_HEIGHT: FH,
        INPUT_NB_CHANNELS: CIN, OUTPUT_NB_CHANNELS: COUT, KERNEL_SIZE: K, FRACTIONAL_BITS: 8
    };

    logic clk = 0, arst_n = 0;
    logic int_mem_we = 0, data_ready = 0, start = 0, a_valid = 0, b_valid = 0;
    logic [15:0] a_input = 0, b_input = 0;
    logic fsm_done, a_ready, b_ready, output_valid, running;
    logic [15:0] output_data;
    logic [XW-1:0] output_x;
    logic [YW-1:0] output_y;
    logic [CW-1:0] output_ch;
    int total = 0, bad = 0;

    modport_chip #(.cfg(TB_CFG)) dut (
        .clk(clk), .arst_n(arst_n), .int_mem_we(int_mem_we), .data_ready(data_ready),
        .fsm_done(fsm_done), .a_input(a_input), .a_valid(a_valid), .a_ready(a_ready),
        .b_input(b_input), .b_valid(b_valid), .b_ready(b_ready), .output_data(output_data),
        .output_valid(output_valid), .output_x(output_x), .output_y(output_y),
        .output_ch(output_ch), .start(start), .running(running)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int w_val(input int mode, input int a);
        return mode == 0 ? 256 : mode == 1 ? 32767 : (a * 37) % 200 - 100;
    endfunction

    function automatic int act_val(input int mode, input int y, input int x, input int kv, input int kh, input int ci);
        int iy, ix;
        if (mode == 0) return 256;
        if (mode == 1) return 32767;
        iy = y + kv - K / 2;
        ix = x + kh - K / 2;
        if (iy < 0 || iy >= FH || ix < 0 || ix >= FW) return 0;
        return ((iy * 7 + ix * 3 + ci * 5) % 50 - 20) * 16;
    endfunction

    function automatic logic [15:0] exp_val(input int mode, input int y, input int x, input int co);
        longint s, sh;
        if (mode == 0) return 16'd4608;
`ifdef SATURATE_EN
        if (mode == 1) return 16'h7fff;
`else
        if (mode == 1) return 16'hee00;
`endif
        s = 0;
        for (int kv = 0; kv < K; kv++)
            for (int kh = 0; kh < K; kh++)
                for (int ci = 0; ci < CIN; ci++)
                    s += longint'(act_val(2, y, x, kv, kh, ci)) * longint'(w_val(2, ((co * K + kv) * K + kh) * CIN + ci));
        sh = s >>> 8;
`ifdef SATURATE_EN
        if (sh > 32767) sh = 32767;
        if (sh < -32768) sh = -32768;
`endif
        return 16'(sh);
    endfunction

    task automatic do_reset;
        arst_n = 1;
        repeat (2) @(posedge clk);
        #1 arst_n = 0;
    endtask

    task automatic load_weights(input int mode);
        int_mem_we = 1;
        a_valid = 1;
        b_valid = 1;
        for (int a = 0; a < DEPTH; a++) begin
            a_input = 16'(a);
            b_input = 16'(w_val(mode, a));
            @(posedge clk); #1;
        end
        a_input = 16'd64;
        b_input = 16'h7fff;
        @(posedge clk); #1;
        a_valid = 0;
        b_valid = 0;
        int_mem_we = 0;
    endtask

    task automatic pulse_data_ready;
        data_ready = 1;
        @(posedge clk); #1;
        data_ready = 0;
    endtask

    task automatic run_compute(input int mode, input logic gap);
        int y = 0, x = 0, co = 0, kv = 0, kh = 0, ci = 0, macs = 0, outs = 0, cyc = 0;
        int ex, ey, ec;
        logic v, rdy;
        logic [15:0] e;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        total++;
        if (running !== 1'b1) begin bad++; $display("FAIL start_running: got %0b expected 1", running); end
        total++;
        if ({a_ready, b_ready} !== 2'b10) begin bad++; $display("FAIL compute_ready: got a=%0b b=%0b expected a=1 b=0", a_ready, b_ready); end
        @(posedge clk); #1;
        while (outs < NOUT && cyc < 5000) begin
            v = macs < NMAC && (!gap || $urandom_range(0, 1) == 1);
            a_valid = v;
            a_input = v ? 16'(act_val(mode, y, x, kv, kh, ci)) : 16'($urandom);
            @(negedge clk);
            rdy = a_ready;
            if (output_valid) begin
                ec = outs % COUT;
                ex = (outs / COUT) % FW;
                ey = outs / (COUT * FW);
                e = exp_val(mode, ey, ex, ec);
                total++;
                if (output_data !== e || output_x !== XW'(ex) || output_y !== YW'(ey) || output_ch !== CW'(ec)) begin
                    bad++;
                    $display("FAIL out%0d: got data=%0d x=%0d y=%0d ch=%0d expected data=%0d x=%0d y=%0d ch=%0d",
                             outs, $signed(output_data), output_x, output_y, output_ch, $signed(e), ex, ey, ec);
                end
                total++;
                if (fsm_done !== (outs == NOUT - 1)) begin bad++; $display("FAIL done_at_out%0d: got %0b expected %0b", outs, fsm_done, outs == NOUT - 1); end
                outs++;
            end else begin
                total++;
                if (fsm_done !== 1'b0) begin bad++; $display("FAIL stray_done: got 1 expected 0 after %0d outputs", outs); end
            end
            @(posedge clk); #1;
            if (v && rdy) begin
                macs++;
                ci++;
                if (ci == CIN) begin
                    ci = 0; kh++;
                    if (kh == K) begin
                        kh = 0; kv++;
                        if (kv == K) begin
                            kv = 0; co++;
                            if (co == COUT) begin
                                co = 0; x++;
                                if (x == FW) begin x = 0; y++; end
                            end
                        end
                    end
                end
            end
            cyc++;
        end
        a_valid = 0;
        total++;
        if (outs != NOUT) begin bad++; $display("FAIL out_count: got %0d expected %0d", outs, NOUT); end
        @(negedge clk);
        total++;
        if (running !== 1'b0) begin bad++; $display("FAIL running_after_done: got %0b expected 0", running); end
        total++;
        if ({output_valid, fsm_done} !== 2'b00) begin bad++; $display("FAIL extra_out: got valid=%0b done=%0b expected 0 0", output_valid, fsm_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        int_mem_we = 1; a_valid = 1; b_valid = 1; start = 1; data_ready = 1;
        #1 arst_n = 1;
        #1;
        total++;
        if ({a_ready, b_ready, running, output_valid, fsm_done} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b expected 00000", {a_ready, b_ready, running, output_valid, fsm_done});
        end
        total++;
        if ({output_data, output_x, output_y, output_ch} !== '0) begin
            bad++; $display("FAIL reset_data: got data=%0d x=%0d y=%0d ch=%0d expected zeros", output_data, output_x, output_y, output_ch);
        end
        repeat (2) @(posedge clk); #1;
        total++;
        if ({a_ready, b_ready, running, output_valid, fsm_done} !== 5'b0) begin
            bad++; $display("FAIL reset_held: got %b expected 00000", {a_ready, b_ready, running, output_valid, fsm_done});
        end
        a_valid = 0; b_valid = 0; start = 0; data_ready = 0;
        arst_n = 0;
        @(negedge clk);
        total++;
        if ({a_ready, b_ready} !== 2'b11) begin bad++; $display("FAIL idle_load_ready: got %b expected 11", {a_ready, b_ready}); end
        int_mem_we = 0;
        #1;
        total++;
        if ({a_ready, b_ready} !== 2'b00) begin bad++; $display("FAIL idle_noload_ready: got %b expected 00", {a_ready, b_ready}); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_gating;
        pulse_data_ready;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        total++;
        if (running !== 1'b0) begin bad++; $display("FAIL start_in_idle: got running=%0b expected 0", running); end
        @(posedge clk); #1;
        load_weights(0);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        total++;
        if (running !== 1'b0) begin bad++; $display("FAIL start_in_load: got running=%0b expected 0", running); end
        @(posedge clk); #1;
        pulse_data_ready;
        @(negedge clk);
        total++;
        if (running !== 1'b0) begin bad++; $display("FAIL wait_idle: got running=%0b expected 0", running); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_compute;
        do_reset;
        load_weights(2);
        pulse_data_ready;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        a_valid = 1;
        a_input = 16'h1234;
        repeat (30) @(posedge clk);
        #3 arst_n = 1;
        #1;
        total++;
        if ({a_ready, b_ready, running, output_valid, fsm_done} !== 5'b0) begin
            bad++; $display("FAIL abort_ctrl: got %b expected 00000", {a_ready, b_ready, running, output_valid, fsm_done});
        end
        total++;
        if ({output_data, output_x, output_y, output_ch} !== '0) begin
            bad++; $display("FAIL abort_data: got data=%0d x=%0d y=%0d ch=%0d expected zeros", output_data, output_x, output_y, output_ch);
        end
        repeat (2) @(posedge clk);
        #1 arst_n = 0;
        for (int i = 0; i < 300; i++) begin
            a_input = 16'($urandom);
            start = 1'($urandom_range(0, 1));
            data_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            total++;
            if ({output_valid, fsm_done, running} !== 3'b000) begin
                bad++; $display("FAIL post_abort%0d: got valid=%0b done=%0b running=%0b expected 0 0 0", i, output_valid, fsm_done, running);
            end
            @(posedge clk); #1;
        end
        a_valid = 0; start = 0; data_ready = 0;
    endtask

    initial begin
        test_reset;
        test_start_gating;
        run_compute(0, 1'b0);
        run_compute(0, 1'b1);
        do_reset;
        load_weights(2);
        pulse_data_ready;
        run_compute(2, 1'b0);
        run_compute(2, 1'b1);
        test_reset_mid_compute;
        do_reset;
        load_weights(1);
        pulse_data_ready;
        run_compute(1, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
